// File: rtl/parking_pkg.sv
// Shared constants and types for the parking bay duration tracker and its
// neighbours (gate controller, fee stage).
package parking_pkg;

  localparam int DEFAULT_TIME_W = 8;
  localparam int DEFAULT_SLOTS  = 4;

  typedef enum logic [0:0] {
    EV_ENTRY = 1'b0,
    EV_EXIT  = 1'b1
  } event_e;

  // Saturation ceiling of a w-bit unsigned counter.
  function automatic logic [63:0] all_ones(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/slot_timer.sv
// Per-bay saturating elapsed-time counter; start wins over stop so a same-cycle
// exit+entry restarts the stay.
module slot_timer
  import parking_pkg::*;
#(
  parameter int TIME_W = DEFAULT_TIME_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              start,
  input  logic              stop,
  output logic [TIME_W-1:0] count,
  output logic              sat,
  output logic              busy
);

  localparam logic [TIME_W-1:0] MAX_COUNT = TIME_W'(all_ones(TIME_W));

  logic [TIME_W-1:0] count_reg;
  logic              sat_reg;
  logic              busy_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      sat_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else if (start) begin
      count_reg <= '0;
      sat_reg   <= 1'b0;
      busy_reg  <= 1'b1;
    end else if (stop) begin
      count_reg <= '0;
      sat_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else if (busy_reg && tick && !sat_reg) begin
      count_reg <= count_reg + 1'b1;
      if (count_reg == MAX_COUNT - 1'b1) sat_reg <= 1'b1;
    end
  end

  assign count = count_reg;
  assign sat   = sat_reg;
  assign busy  = busy_reg;

endmodule

// File: rtl/parking_duration_tracker.sv
// Multi-bay parking duration tracker: decodes entry/exit events, checks them,
// and registers the exit duration and occupancy summary.
module parking_duration_tracker
  import parking_pkg::*;
#(
  parameter int TIME_W = DEFAULT_TIME_W,
  parameter int SLOTS  = DEFAULT_SLOTS,
  parameter int SLOT_W = $clog2(SLOTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              in_valid,
  input  logic [SLOT_W-1:0] in_slot,
  input  logic              out_valid,
  input  logic [SLOT_W-1:0] out_slot,
  output logic              dur_valid,
  output logic [SLOT_W-1:0] dur_slot,
  output logic [TIME_W-1:0] duration,
  output logic              dur_sat,
  output logic              err_occupied,
  output logic              err_empty,
  output logic              err_slot,
  output logic [SLOTS-1:0]  occupied,
  output logic [SLOT_W:0]   free_count
);

  localparam logic [TIME_W-1:0] MAX_COUNT = TIME_W'(all_ones(TIME_W));
  localparam logic [SLOT_W:0]   SLOTS_CNT = (SLOT_W + 1)'(SLOTS);

  logic [TIME_W-1:0] count_arr [SLOTS];
  logic [SLOTS-1:0]  sat_vec, busy_vec, start_vec, stop_vec, occ_next;

  logic in_range, out_range, in_ok, out_ok;
  logic exit_hit, exit_empty, same_bay, entry_ok, entry_clash;
  logic [TIME_W-1:0] sel_count, exit_count;
  logic              sel_sat, adv, exit_sat;
  logic [SLOT_W:0]   free_next;

  logic              dur_valid_reg, dur_sat_reg;
  logic [SLOT_W-1:0] dur_slot_reg;
  logic [TIME_W-1:0] duration_reg;
  logic              err_occupied_reg, err_empty_reg, err_slot_reg;
  logic [SLOT_W:0]   free_count_reg;

  assign in_range  = {1'b0, in_slot} < SLOTS_CNT;
  assign out_range = {1'b0, out_slot} < SLOTS_CNT;
  assign in_ok     = in_valid && in_range;
  assign out_ok    = out_valid && out_range;

  assign exit_hit    = out_ok && busy_vec[out_slot];
  assign exit_empty  = out_ok && !busy_vec[out_slot];
  // A same-bay exit frees the bay before the entry is judged.
  assign same_bay    = exit_hit && (out_slot == in_slot);
  assign entry_ok    = in_ok && (!busy_vec[in_slot] || same_bay);
  assign entry_clash = in_ok && busy_vec[in_slot] && !same_bay;

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_bay
      assign start_vec[gi] = entry_ok && (in_slot == SLOT_W'(gi));
      assign stop_vec[gi]  = exit_hit && (out_slot == SLOT_W'(gi));
      assign occ_next[gi]  = start_vec[gi] | (busy_vec[gi] & ~stop_vec[gi]);

      slot_timer #(.TIME_W(TIME_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .start (start_vec[gi]),
        .stop  (stop_vec[gi]),
        .count (count_arr[gi]),
        .sat   (sat_vec[gi]),
        .busy  (busy_vec[gi])
      );
    end
  endgenerate

  // Reported duration includes a tick arriving in the exit cycle.
  assign sel_count  = count_arr[out_slot];
  assign sel_sat    = sat_vec[out_slot];
  assign adv        = tick && !sel_sat;
  assign exit_count = adv ? sel_count + 1'b1 : sel_count;
  assign exit_sat   = sel_sat || (adv && (sel_count == MAX_COUNT - 1'b1));

  always_comb begin
    free_next = SLOTS_CNT;
    for (int i = 0; i < SLOTS; i++) begin
      free_next = free_next - {{SLOT_W{1'b0}}, occ_next[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dur_valid_reg    <= 1'b0;
      dur_slot_reg     <= '0;
      duration_reg     <= '0;
      dur_sat_reg      <= 1'b0;
      err_occupied_reg <= 1'b0;
      err_empty_reg    <= 1'b0;
      err_slot_reg     <= 1'b0;
      free_count_reg   <= SLOTS_CNT;
    end else begin
      dur_valid_reg    <= exit_hit;
      if (exit_hit) begin
        dur_slot_reg <= out_slot;
        duration_reg <= exit_count;
        dur_sat_reg  <= exit_sat;
      end
      err_occupied_reg <= entry_clash;
      err_empty_reg    <= exit_empty;
      err_slot_reg     <= (in_valid && !in_range) || (out_valid && !out_range);
      free_count_reg   <= free_next;
    end
  end

  assign dur_valid    = dur_valid_reg;
  assign dur_slot     = dur_slot_reg;
  assign duration     = duration_reg;
  assign dur_sat      = dur_sat_reg;
  assign err_occupied = err_occupied_reg;
  assign err_empty    = err_empty_reg;
  assign err_slot     = err_slot_reg;
  assign occupied     = busy_vec;
  assign free_count   = free_count_reg;

endmodule

// File: tb/tb_parking_duration_tracker.sv
// Directed bench for parking_duration_tracker: a 4-bay instance plus a 3-bay
// instance for the out-of-range slot case.
module tb_parking_duration_tracker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // 4-bay, 8-bit instance
  logic       tick = 0, in_valid = 0, out_valid = 0;
  logic [1:0] in_slot = 0, out_slot = 0;
  logic       dur_valid, dur_sat, err_occupied, err_empty, err_slot;
  logic [1:0] dur_slot;
  logic [7:0] duration;
  logic [3:0] occupied;
  logic [2:0] free_count;

  parking_duration_tracker #(.TIME_W(8), .SLOTS(4)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .in_valid(in_valid), .in_slot(in_slot),
    .out_valid(out_valid), .out_slot(out_slot),
    .dur_valid(dur_valid), .dur_slot(dur_slot), .duration(duration),
    .dur_sat(dur_sat), .err_occupied(err_occupied), .err_empty(err_empty),
    .err_slot(err_slot), .occupied(occupied), .free_count(free_count)
  );

  // 3-bay instance
  logic       tick3 = 0, in_valid3 = 0, out_valid3 = 0;
  logic [1:0] in_slot3 = 0, out_slot3 = 0;
  logic       dur_valid3, dur_sat3, err_occupied3, err_empty3, err_slot3;
  logic [1:0] dur_slot3;
  logic [7:0] duration3;
  logic [2:0] occupied3;
  logic [2:0] free_count3;

  parking_duration_tracker #(.TIME_W(8), .SLOTS(3)) dut3 (
    .clk(clk), .rst(rst), .tick(tick3),
    .in_valid(in_valid3), .in_slot(in_slot3),
    .out_valid(out_valid3), .out_slot(out_slot3),
    .dur_valid(dur_valid3), .dur_slot(dur_slot3), .duration(duration3),
    .dur_sat(dur_sat3), .err_occupied(err_occupied3), .err_empty(err_empty3),
    .err_slot(err_slot3), .occupied(occupied3), .free_count(free_count3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tick = 0; in_valid = 0; out_valid = 0;
  endtask

  task automatic enter(input logic [1:0] s);
    in_valid = 1; in_slot = s; step(); in_valid = 0;
  endtask

  task automatic ticks(input int n);
    tick = 1;
    for (int i = 0; i < n; i++) step();
    tick = 0;
  endtask

  task automatic test_reset();
    rst = 1; step(); step(); rst = 0;
    vectors++;
    if (occupied !== 4'b0000 || free_count !== 3'd4 || dur_valid !== 1'b0 ||
        duration !== 8'd0 || dur_slot !== 2'd0 || dur_sat !== 1'b0 ||
        err_occupied !== 1'b0 || err_empty !== 1'b0 || err_slot !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: occ=%b free=%0d dv=%b dur=%0d slot=%0d sat=%b errs=%b%b%b required occ=0000 free=4 all zero",
               occupied, free_count, dur_valid, duration, dur_slot, dur_sat, err_occupied, err_empty, err_slot);
    end
    vectors++;
    if (occupied3 !== 3'b000 || free_count3 !== 3'd3) begin
      miscompares++;
      $display("FAIL reset3: occ=%b free=%0d required occ=000 free=3", occupied3, free_count3);
    end
    $display("reset: occ=%b free=%0d", occupied, free_count);
  endtask

  task automatic test_basic();
    enter(2'd2);
    vectors++;
    if (occupied !== 4'b0100 || free_count !== 3'd3) begin
      miscompares++;
      $display("FAIL basic_entry: occ=%b free=%0d required occ=0100 free=3", occupied, free_count);
    end
    ticks(5);
    out_valid = 1; out_slot = 2'd2; step(); out_valid = 0;
    vectors++;
    if (dur_valid !== 1'b1 || dur_slot !== 2'd2 || duration !== 8'd5 || dur_sat !== 1'b0 ||
        occupied !== 4'b0000 || free_count !== 3'd4) begin
      miscompares++;
      $display("FAIL basic_exit: dv=%b slot=%0d dur=%0d sat=%b occ=%b free=%0d required 1/2/5/0/0000/4",
               dur_valid, dur_slot, duration, dur_sat, occupied, free_count);
    end
    $display("basic: bay %0d duration %0d", dur_slot, duration);
    step();
    vectors++;
    if (dur_valid !== 1'b0 || duration !== 8'd5 || dur_slot !== 2'd2) begin
      miscompares++;
      $display("FAIL basic_hold: dv=%b dur=%0d slot=%0d required 0/5/2", dur_valid, duration, dur_slot);
    end
  endtask

  task automatic test_saturate();
    enter(2'd0);
    ticks(300);
    out_valid = 1; out_slot = 2'd0; step(); out_valid = 0;
    vectors++;
    if (dur_valid !== 1'b1 || duration !== 8'd255 || dur_sat !== 1'b1 || dur_slot !== 2'd0) begin
      miscompares++;
      $display("FAIL saturate: dv=%b dur=%0d sat=%b slot=%0d required 1/255/1/0",
               dur_valid, duration, dur_sat, dur_slot);
    end
    $display("saturate: bay 0 duration %0d sat %b", duration, dur_sat);
    // 254 ticks then an exit-cycle tick reaches the ceiling exactly
    enter(2'd0);
    ticks(254);
    tick = 1; out_valid = 1; out_slot = 2'd0; step(); idle();
    vectors++;
    if (duration !== 8'd255 || dur_sat !== 1'b1) begin
      miscompares++;
      $display("FAIL saturate_edge: dur=%0d sat=%b required 255/1", duration, dur_sat);
    end
    $display("saturate_edge: duration %0d sat %b", duration, dur_sat);
  endtask

  task automatic test_double_entry();
    enter(2'd1);
    ticks(3);
    enter(2'd1);
    vectors++;
    if (err_occupied !== 1'b1 || occupied !== 4'b0010 || free_count !== 3'd3) begin
      miscompares++;
      $display("FAIL double_entry_err: err=%b occ=%b free=%0d required 1/0010/3", err_occupied, occupied, free_count);
    end
    step();
    vectors++;
    if (err_occupied !== 1'b0) begin
      miscompares++;
      $display("FAIL double_entry_pulse: err=%b required 0", err_occupied);
    end
    ticks(2);
    out_valid = 1; out_slot = 2'd1; step(); out_valid = 0;
    vectors++;
    if (dur_valid !== 1'b1 || duration !== 8'd5 || dur_slot !== 2'd1) begin
      miscompares++;
      $display("FAIL double_entry_dur: dv=%b dur=%0d slot=%0d required 1/5/1", dur_valid, duration, dur_slot);
    end
    $display("double_entry: bay 1 duration %0d", duration);
  endtask

  task automatic test_errors();
    out_valid = 1; out_slot = 2'd3; step(); out_valid = 0;
    vectors++;
    if (err_empty !== 1'b1 || dur_valid !== 1'b0 || occupied !== 4'b0000) begin
      miscompares++;
      $display("FAIL empty_exit: err_empty=%b dv=%b occ=%b required 1/0/0000", err_empty, dur_valid, occupied);
    end
    $display("empty_exit: err_empty %b", err_empty);
    // out-of-range exit alongside a valid entry on the 3-bay instance
    out_valid3 = 1; out_slot3 = 2'd3; in_valid3 = 1; in_slot3 = 2'd1; step();
    out_valid3 = 0; in_valid3 = 0;
    vectors++;
    if (err_slot3 !== 1'b1 || err_empty3 !== 1'b0 || dur_valid3 !== 1'b0 ||
        occupied3 !== 3'b010 || free_count3 !== 3'd2) begin
      miscompares++;
      $display("FAIL bad_slot: err_slot=%b err_empty=%b dv=%b occ=%b free=%0d required 1/0/0/010/2",
               err_slot3, err_empty3, dur_valid3, occupied3, free_count3);
    end
    $display("bad_slot: err_slot %b occ %b", err_slot3, occupied3);
    step();
    vectors++;
    if (err_slot3 !== 1'b0 || err_empty !== 1'b0) begin
      miscompares++;
      $display("FAIL err_pulse: err_slot=%b err_empty=%b required 0/0", err_slot3, err_empty);
    end
  endtask

  task automatic test_same_bay();
    enter(2'd0);
    ticks(7);
    tick = 1; out_valid = 1; out_slot = 2'd0; in_valid = 1; in_slot = 2'd0; step(); idle();
    vectors++;
    if (dur_valid !== 1'b1 || duration !== 8'd8 || dur_slot !== 2'd0 || occupied[0] !== 1'b1 ||
        err_occupied !== 1'b0 || err_empty !== 1'b0 || free_count !== 3'd3) begin
      miscompares++;
      $display("FAIL same_bay: dv=%b dur=%0d occ=%b eo=%b ee=%b free=%0d required 1/8/xxx1/0/0/3",
               dur_valid, duration, occupied, err_occupied, err_empty, free_count);
    end
    $display("same_bay: bay 0 duration %0d", duration);
    ticks(2);
    out_valid = 1; out_slot = 2'd0; step(); out_valid = 0;
    vectors++;
    if (duration !== 8'd2 || occupied !== 4'b0000) begin
      miscompares++;
      $display("FAIL same_bay_restart: dur=%0d occ=%b required 2/0000", duration, occupied);
    end
    // exit+entry on an empty bay: error on the exit, entry still accepted
    out_valid = 1; out_slot = 2'd3; in_valid = 1; in_slot = 2'd3; step(); idle();
    vectors++;
    if (err_empty !== 1'b1 || err_occupied !== 1'b0 || dur_valid !== 1'b0 || occupied !== 4'b1000) begin
      miscompares++;
      $display("FAIL same_bay_empty: ee=%b eo=%b dv=%b occ=%b required 1/0/0/1000",
               err_empty, err_occupied, dur_valid, occupied);
    end
    $display("same_bay_empty: occ %b", occupied);
    out_valid = 1; out_slot = 2'd3; step(); out_valid = 0;
  endtask

  task automatic test_back_to_back();
    enter(2'd0); enter(2'd1); enter(2'd2);
    ticks(1);
    in_valid = 1; in_slot = 2'd3; out_valid = 1; out_slot = 2'd0; step(); idle();
    vectors++;
    if (dur_valid !== 1'b1 || dur_slot !== 2'd0 || duration !== 8'd1 ||
        occupied !== 4'b1110 || free_count !== 3'd1) begin
      miscompares++;
      $display("FAIL diff_bays: dv=%b slot=%0d dur=%0d occ=%b free=%0d required 1/0/1/1110/1",
               dur_valid, dur_slot, duration, occupied, free_count);
    end
    enter(2'd0);
    vectors++;
    if (occupied !== 4'b1111 || free_count !== 3'd0) begin
      miscompares++;
      $display("FAIL full: occ=%b free=%0d required 1111/0", occupied, free_count);
    end
    $display("full: free_count %0d", free_count);
    ticks(4);
    rst = 1; tick = 1; step(); rst = 0; tick = 0;
    vectors++;
    if (occupied !== 4'b0000 || free_count !== 3'd4 || dur_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: occ=%b free=%0d dv=%b required 0000/4/0", occupied, free_count, dur_valid);
    end
    step();
    vectors++;
    if (dur_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_quiet: dv=%b required 0", dur_valid);
    end
    enter(2'd3);
    ticks(2);
    out_valid = 1; out_slot = 2'd3; step(); out_valid = 0;
    vectors++;
    if (dur_valid !== 1'b1 || duration !== 8'd2 || dur_slot !== 2'd3) begin
      miscompares++;
      $display("FAIL after_reset: dv=%b dur=%0d slot=%0d required 1/2/3", dur_valid, duration, dur_slot);
    end
    $display("after_reset: bay 3 duration %0d", duration);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_double_entry();
    test_errors();
    test_same_bay();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/parking_duration_tracker.md
Name: parking_duration_tracker

Overview:
- Multi-slot successor to the single-pair parking time calculator.
- Tracks SLOTS parking bays at once. Each bay has its own saturating elapsed-time counter, driven by a shared time-base tick.
- On car exit it reports the bay's parked duration, then frees the bay.
- Sits between the gate/slot-allocation logic (entry/exit events) and the fee/billing stage (consumes the duration).

Parameters:
- TIME_W, 8, width of the duration counter in ticks; saturates at 2^TIME_W-1.
- SLOTS, 4, number of parking bays tracked (≥2).
- SLOT_W, $clog2(SLOTS), width of slot index ports.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle time-base pulse; one unit of parked time.
- in_valid  in  1  car entry event this cycle.
- in_slot  in  SLOT_W  bay being entered.
- out_valid  in  1  car exit event this cycle.
- out_slot  in  SLOT_W  bay being vacated.
- dur_valid  out  1  one-cycle pulse: duration result valid.
- dur_slot  out  SLOT_W  bay the result belongs to.
- duration  out  TIME_W  parked time in ticks.
- dur_sat  out  1  duration saturated (true time ≥ 2^TIME_W-1).
- err_occupied  out  1  pulse: entry to an already-occupied bay.
- err_empty  out  1  pulse: exit from an empty bay.
- err_slot  out  1  pulse: in_slot or out_slot ≥ SLOTS on a valid event.
- occupied  out  SLOTS  per-bay occupancy, bit i = bay i.
- free_count  out  SLOT_W+1  number of unoccupied bays.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) applies to all state and outputs:
  - all counters 0; occupied=0; free_count=SLOTS.
  - dur_valid, dur_sat, err_* = 0; dur_slot=0; duration=0.
- rst mid-operation discards every stored duration. No result is emitted for bays occupied at reset.
- Per-bay counter:
  - While occupied, +1 on each cycle with tick=1.
  - Holds at all-ones once reached, and sets the bay's sticky sat flag.
  - Unoccupied bays hold at 0.
- Valid entry to a free bay: occupied[i]←1, counter←0, sat←0. A tick in the entry cycle is not counted.
- Valid exit from an occupied bay: result registered at the next edge, so latency is 1 cycle.
  - Outputs: dur_valid=1, dur_slot=out_slot, duration = counter value including any tick in the exit cycle (saturated), dur_sat = that bay's sat flag.
  - Bay is cleared at the same edge.
- dur_valid and err_* are single-cycle pulses. duration and dur_slot hold their last value between pulses.
- Error cases:
  - Entry to an occupied bay: err_occupied pulses next cycle; the bay's counter and occupancy are unchanged.
  - Exit from an empty bay: err_empty pulses; no dur_valid.
  - Out-of-range slot on a valid event: err_slot pulses and the event is ignored. The other event in the same cycle is still processed.
- Simultaneous entry and exit, different bays: both processed in the same cycle.
- Simultaneous entry and exit, same bay:
  - Exit is processed first, so duration is reported for the old stay.
  - Entry then restarts the counter at 0 with occupied staying 1.
  - No error is raised. This also applies when the bay was empty beforehand: err_empty pulses, then the entry succeeds.
- free_count and occupied are registered and reflect state after the edge. free_count = SLOTS − popcount(occupied).
- Counter arithmetic is unsigned TIME_W bits. No wrap-around is allowed; saturation replaces it.

Decomposition:
- Package parking_pkg holds:
  - default TIME_W/SLOTS constants;
  - the saturating all-ones constant function;
  - the event-type encoding (ENTRY/EXIT) shared with the gate controller and the fee stage.
- One sub-module, slot_timer:
  - Interface: clk, rst, tick, start, stop, count[TIME_W-1:0], sat, busy.
  - Instantiated SLOTS times via generate.
  - The top handles decode, the error checks, the result register and free_count.

Test Plan:
- Reset, then entry to bay 2, 5 ticks, exit bay 2 → one cycle later: dur_valid=1, dur_slot=2, duration=5, dur_sat=0; occupied=0000, free_count=4.
- TIME_W=8: entry bay 0, 300 ticks, exit → duration=255, dur_sat=1.
- Entry bay 1 then entry bay 1 again → err_occupied pulses once; the later exit reports the duration measured from the first entry.
- Exit bay 3 while empty → err_empty=1, dur_valid=0. out_slot=3 with SLOTS=3 → err_slot=1, no state change.
- Bay 0 occupied with 7 ticks; same-cycle exit+entry on bay 0 with tick=1 → duration=8; the new stay starts at 0 and occupied[0] stays 1.
- Fill all 4 bays → free_count=0. Assert rst mid-count → occupied=0, free_count=4, no dur_valid; subsequent entries count from 0.
